// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the masked AES-128 core scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   BLK_W    width of one AES state share
//   SHARES   default number of Boolean shares per 128-bit value
//   state_t  scheduler FSM states
package aes_sched_pkg;

  localparam int BLK_W  = 128;
  localparam int SHARES = 2;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RND,
    LOAD,
    RUN,
    HOLD
  } state_t;

endpackage

// File: rtl/aes_core_scheduler_rr_arbiter2.sv
// Two-input round-robin arbiter; picks the sole requester, or the one not granted last on a tie.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the grant is consumed.
//
// Ports:
//   i_req          request vector, bit i = requester i
//   i_last_grant   index granted on the previous accepted transaction
//   o_gnt_onehot   one-hot grant (zero when nobody requests)
//   o_gnt_idx      index of the granted requester (0 when nobody requests)
module rr_arbiter2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic [1:0] o_gnt_onehot,
  output logic       o_gnt_idx
);

  always_comb begin
    o_gnt_idx    = 1'b0;
    o_gnt_onehot = 2'b00;
    case (i_req)
      2'b01: begin
        o_gnt_idx    = 1'b0;
        o_gnt_onehot = 2'b01;
      end
      2'b10: begin
        o_gnt_idx    = 1'b1;
        o_gnt_onehot = 2'b10;
      end
      2'b11: begin
        // Tie: hand the slot to whoever did not win last time.
        o_gnt_idx    = ~i_last_grant;
        o_gnt_onehot = i_last_grant ? 2'b01 : 2'b10;
      end
      default: begin
        o_gnt_idx    = 1'b0;
        o_gnt_onehot = 2'b00;
      end
    endcase
  end

endmodule

// File: rtl/aes_core_scheduler.sv
// Shares one masked AES-128 core between two requesters: arbitrate, fetch a mask token, run, respond.
// Latency: accept -> WAIT_RND (>=1) -> LOAD (LOAD_CYCLES) -> RUN (core latency, max TIMEOUT) -> HOLD.
// Backpressure: one transaction in flight; requests and tokens stall until IDLE/WAIT_RND, response holds until i_resp_ready.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   i_req_valid     per-requester request valid
//   o_req_ready     one-hot accept, only while idle (combinational from i_req_valid)
//   i_req_pt/key    shared plaintexts/keys, requester i at [i*SHARES*128 +: SHARES*128]
//   i_rnd_valid     PRNG has fresh mask material
//   o_rnd_ready     consume one randomness token (combinational, WAIT_RND only)
//   o_core_start    AES core reset/load strobe, high for LOAD_CYCLES cycles
//   o_core_pt/key   latched operands for the core
//   i_core_done     core finished; only looked at during RUN
//   i_core_ct       core ciphertext shares
//   o_resp_valid    response pending, i_resp_ready accepts it
//   o_resp_ct       captured ciphertext shares (zero on watchdog abort)
//   o_resp_id       requester index the response belongs to
//   o_resp_err      watchdog abort flag
//   o_busy          a transaction is in flight
module aes_core_scheduler
  import aes_sched_pkg::*;
#(
  parameter int SHARES      = aes_sched_pkg::SHARES,
  parameter int LOAD_CYCLES = 1,
  parameter int TIMEOUT     = 127,
  parameter int CNT_W       = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    i_req_valid,
  output logic [1:0]                    o_req_ready,
  input  logic [2*SHARES*BLK_W-1:0]     i_req_pt,
  input  logic [2*SHARES*BLK_W-1:0]     i_req_key,
  input  logic                          i_rnd_valid,
  output logic                          o_rnd_ready,
  output logic                          o_core_start,
  output logic [SHARES*BLK_W-1:0]       o_core_pt,
  output logic [SHARES*BLK_W-1:0]       o_core_key,
  input  logic                          i_core_done,
  input  logic [SHARES*BLK_W-1:0]       i_core_ct,
  output logic                          o_resp_valid,
  input  logic                          i_resp_ready,
  output logic [SHARES*BLK_W-1:0]       o_resp_ct,
  output logic                          o_resp_id,
  output logic                          o_resp_err,
  output logic                          o_busy
);

  localparam int SW   = SHARES * BLK_W;
  localparam int LD_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

  state_t            r_state;
  logic              r_last_grant;
  logic              r_id;
  logic [SW-1:0]     r_core_pt;
  logic [SW-1:0]     r_core_key;
  logic              r_core_start;
  logic [LD_W-1:0]   r_ld_cnt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_resp_valid;
  logic [SW-1:0]     r_resp_ct;
  logic              r_resp_id;
  logic              r_resp_err;
  logic              r_busy;

  logic [1:0]        w_gnt_onehot;
  logic              w_gnt_idx;
  logic              w_accept;
  logic              w_load_last;
  logic              w_timeout;
  logic [SW-1:0]     w_sel_pt;
  logic [SW-1:0]     w_sel_key;

  rr_arbiter2 u_arb (
    .i_req        (i_req_valid),
    .i_last_grant (r_last_grant),
    .o_gnt_onehot (w_gnt_onehot),
    .o_gnt_idx    (w_gnt_idx)
  );

  // Ready strobes are masked during reset: the state update is suppressed in
  // that cycle, so advertising ready would silently drop a handshake.
  assign o_req_ready = (r_state == IDLE && !rst) ? w_gnt_onehot : 2'b00;
  assign o_rnd_ready = (r_state == WAIT_RND) && !rst;

  assign w_accept    = (r_state == IDLE) && (i_req_valid != 2'b00);
  assign w_load_last = (r_ld_cnt == LD_W'(LOAD_CYCLES - 1));
  assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT - 1));

  assign w_sel_pt    = w_gnt_idx ? i_req_pt[SW +: SW]  : i_req_pt[0 +: SW];
  assign w_sel_key   = w_gnt_idx ? i_req_key[SW +: SW] : i_req_key[0 +: SW];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_core_pt    <= '0;
      r_core_key   <= '0;
      r_core_start <= 1'b0;
      r_ld_cnt     <= '0;
      r_cnt        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_ct    <= '0;
      r_resp_id    <= 1'b0;
      r_resp_err   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_core_pt    <= w_sel_pt;
            r_core_key   <= w_sel_key;
            r_id         <= w_gnt_idx;
            r_last_grant <= w_gnt_idx;
            r_busy       <= 1'b1;
            r_state      <= WAIT_RND;
          end
        end

        WAIT_RND: begin
          if (i_rnd_valid) begin
            r_core_start <= 1'b1;
            r_ld_cnt     <= '0;
            r_state      <= LOAD;
          end
        end

        LOAD: begin
          if (w_load_last) begin
            r_core_start <= 1'b0;
            r_cnt        <= '0;
            r_state      <= RUN;
          end else begin
            r_ld_cnt <= r_ld_cnt + LD_W'(1);
          end
        end

        RUN: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // A done flag arriving on the last watchdog cycle still counts.
          if (i_core_done) begin
            r_resp_ct    <= i_core_ct;
            r_resp_err   <= 1'b0;
            r_resp_id    <= r_id;
            r_resp_valid <= 1'b1;
            r_state      <= HOLD;
          end else if (w_timeout) begin
            r_resp_ct    <= '0;
            r_resp_err   <= 1'b1;
            r_resp_id    <= r_id;
            r_resp_valid <= 1'b1;
            r_state      <= HOLD;
          end
        end

        HOLD: begin
          if (i_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_core_start = r_core_start;
  assign o_core_pt    = r_core_pt;
  assign o_core_key   = r_core_key;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_ct    = r_resp_ct;
  assign o_resp_id    = r_resp_id;
  assign o_resp_err   = r_resp_err;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_aes_core_scheduler.sv
// Bench for aes_core_scheduler: table of single transactions, hand sequences, randomized traffic.
// Latency: n/a.
// Backpressure: the bench throttles rnd_valid and resp_ready itself.
module tb_aes_core_scheduler;

  localparam int SW      = 256;
  localparam int TIMEOUT = 127;
  localparam int NRAND   = 40;

  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic            clk;
  logic            rst;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [2*SW-1:0] req_pt;
  logic [2*SW-1:0] req_key;
  logic            rnd_valid;
  logic            rnd_ready;
  logic            core_start;
  logic [SW-1:0]   core_pt;
  logic [SW-1:0]   core_key;
  logic            core_done = 1'b0;
  logic [SW-1:0]   core_ct   = '0;
  logic            resp_valid;
  logic            resp_ready;
  logic [SW-1:0]   resp_ct;
  logic            resp_id;
  logic            resp_err;
  logic            busy;

  int n_vec = 0;
  int n_err = 0;

  aes_core_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_pt     (req_pt),
    .i_req_key    (req_key),
    .i_rnd_valid  (rnd_valid),
    .o_rnd_ready  (rnd_ready),
    .o_core_start (core_start),
    .o_core_pt    (core_pt),
    .o_core_key   (core_key),
    .i_core_done  (core_done),
    .i_core_ct    (core_ct),
    .o_resp_valid (resp_valid),
    .i_resp_ready (resp_ready),
    .o_resp_ct    (resp_ct),
    .o_resp_id    (resp_id),
    .o_resp_err   (resp_err),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1, "bench time limit reached");
  end

  function automatic logic [SW-1:0] rand256();
    logic [SW-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Stand-in for the encryption: the real FIPS-197 answer for the known vector,
  // an arbitrary keyed mix otherwise. Only routing of operands matters here.
  function automatic logic [SW-1:0] fake_aes(input logic [SW-1:0] pt, input logic [SW-1:0] key);
    if (pt == {FIPS_PT, 128'h0} && key == {FIPS_KEY, 128'h0}) return {FIPS_CT, 128'h0};
    return pt ^ {key[127:0], key[255:128]} ^ {8{32'h5a3c_96e1}};
  endfunction

  // Core model: done pulses exactly core_lat cycles after core_start falls (0 = never).
  int core_lat = 1;
  int core_cnt = 0;
  bit core_act = 1'b0;
  always begin
    @(posedge clk);
    #1;
    core_done = 1'b0;
    core_ct   = rand256();
    if (core_start) begin
      core_act = 1'b1;
      core_cnt = 0;
    end else if (core_act) begin
      core_cnt++;
      if (core_lat != 0 && core_cnt == core_lat) begin
        core_done = 1'b1;
        core_ct   = fake_aes(core_pt, core_key);
        core_act  = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic chk_reset_state();
    @(negedge clk);
    chk("rst_req_ready",  req_ready,  0);
    chk("rst_rnd_ready",  rnd_ready,  0);
    chk("rst_core_start", core_start, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_ct",    resp_ct,    0);
    chk("rst_resp_id",    resp_id,    0);
    chk("rst_resp_err",   resp_err,   0);
    chk("rst_busy",       busy,       0);
  endtask

  typedef struct {
    int   id;
    int   rnd_dly;
    int   lat;
    int   rdy_dly;
    logic exp_err;
    int   exp_lat;
  } txn_t;

  // One complete transaction from a single requester, checking timing on the way.
  task automatic run_txn(input txn_t t, input logic [SW-1:0] pt, input logic [SW-1:0] key);
    int            cyc, run_start, start_cnt, start_first, tokens;
    bit            rnd_up, bad_wait, stable;
    logic [SW-1:0] exp_ct, g_ct;
    logic          g_id, g_err;
    exp_ct = t.exp_err ? '0 : fake_aes(pt, key);
    step();
    req_valid = 2'b00;
    req_valid[t.id] = 1'b1;
    req_pt[t.id*SW +: SW]  = pt;
    req_key[t.id*SW +: SW] = key;
    core_lat   = t.lat;
    rnd_valid  = 1'b0;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("req_ready_onehot", req_ready, (t.id == 1) ? 2'b10 : 2'b01);
    step();
    // Requester inputs change right after accept; the latched copy must not follow.
    req_valid = 2'b00;
    req_pt    = {rand256(), rand256()};
    req_key   = {rand256(), rand256()};
    cyc = 0; run_start = -1; start_cnt = 0; start_first = -1; tokens = 0;
    rnd_up = 1'b0; bad_wait = 1'b0;
    while (cyc < 400) begin
      if (cyc == t.rnd_dly) begin
        rnd_valid = 1'b1;
        rnd_up    = 1'b1;
      end
      @(negedge clk);
      if (rnd_valid && rnd_ready) tokens++;
      if (!rnd_up && (core_start || !rnd_ready)) bad_wait = 1'b1;
      if (core_start) begin
        start_cnt++;
        if (start_first < 0) start_first = cyc;
      end else if (start_first >= 0 && run_start < 0) begin
        run_start = cyc;
      end
      if (resp_valid) break;
      step();
      cyc++;
    end
    chk("resp_seen",       resp_valid,  1);
    chk("wait_rnd_quiet",  bad_wait,    0);
    chk("rnd_tokens",      tokens,      1);
    chk("load_after_rnd",  start_first, t.rnd_dly + 1);
    chk("start_width",     start_cnt,   1);
    chk("run_latency",     cyc - run_start, t.exp_lat);
    chk("resp_ct",         resp_ct,     exp_ct);
    chk("resp_id",         resp_id,     t.id);
    chk("resp_err",        resp_err,    t.exp_err);
    g_ct = resp_ct; g_id = resp_id; g_err = resp_err;
    stable = 1'b1;
    for (int i = 0; i < t.rdy_dly; i++) begin
      step();
      req_valid = 2'b11;
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_ct !== g_ct || resp_id !== g_id ||
          resp_err !== g_err || req_ready !== 2'b00 || busy !== 1'b1)
        stable = 1'b0;
    end
    chk("hold_stable", stable, 1);
    step();
    resp_ready = 1'b1;
    @(negedge clk);
    chk("no_accept_in_handshake", req_ready, 0);
    step();
    resp_ready = 1'b0;
    req_valid  = 2'b00;
    rnd_valid  = 1'b0;
    @(negedge clk);
    chk("post_resp_valid", resp_valid, 0);
    chk("post_busy",       busy,       0);
  endtask

  typedef struct {
    logic          id;
    logic [SW-1:0] ct;
    logic          err;
  } exp_t;

  txn_t tbl[6];

  initial begin
    logic [SW-1:0] pt, key;
    logic          gnt_seq[4];
    logic          id_seq[4];
    int            ng, nr;
    bit            seen, bad;
    exp_t          q[$];
    exp_t          e;
    logic [SW-1:0] p[2];
    logic [SW-1:0] k[2];
    logic [1:0]    acc;
    int            last_g, inflight, done_txn, tokens, exp_g, lat;

    //          id rnd lat  rdy err  lat_exp
    tbl[0] = '{0,  0,  3,   0,  1'b0, 3};
    tbl[1] = '{1,  5,  1,   0,  1'b0, 1};
    tbl[2] = '{0,  0,  0,   0,  1'b1, TIMEOUT};
    tbl[3] = '{1,  2,  127, 10, 1'b0, TIMEOUT};
    tbl[4] = '{0,  1,  128, 3,  1'b1, TIMEOUT};
    tbl[5] = '{1,  0,  10,  10, 1'b0, 10};

    rst = 1'b1; req_valid = 2'b00; req_pt = '0; req_key = '0;
    rnd_valid = 1'b0; resp_ready = 1'b0;
    do_reset();
    chk_reset_state();

    // Table of single transactions; entry 0 carries the FIPS-197 vector.
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        pt  = {FIPS_PT, 128'h0};
        key = {FIPS_KEY, 128'h0};
      end else begin
        pt  = rand256();
        key = rand256();
      end
      run_txn(tbl[i], pt, key);
    end

    // Both requesters valid out of reset and always resubmitting: strict alternation from 0.
    step();
    rst = 1'b1;
    req_valid = 2'b11;
    req_pt  = {rand256(), rand256()};
    req_key = {rand256(), rand256()};
    rnd_valid = 1'b1; resp_ready = 1'b1; core_lat = 2;
    step();
    step();
    rst = 1'b0;
    ng = 0; nr = 0;
    for (int c = 0; c < 400 && nr < 4; c++) begin
      @(negedge clk);
      if (req_ready != 2'b00 && ng < 4) begin
        gnt_seq[ng] = req_ready[1];
        ng++;
      end
      if (resp_valid && resp_ready) begin
        id_seq[nr] = resp_id;
        nr++;
      end
      step();
    end
    req_valid = 2'b00; rnd_valid = 1'b0; resp_ready = 1'b0;
    chk("alt_resp_count", nr, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("alt_grant_%0d", i), gnt_seq[i], i % 2);
      chk($sformatf("alt_id_%0d", i),    id_seq[i],  i % 2);
    end

    // Reset pulse while the core is running: the transaction is dropped silently.
    step();
    req_valid = 2'b10;
    req_pt[SW +: SW] = rand256();
    core_lat = 0; rnd_valid = 1'b1; resp_ready = 1'b1;
    step();
    req_valid = 2'b00;
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (core_start) seen = 1'b1;
      else if (seen) break;
      step();
    end
    chk("rst_test_reached_run", seen && !core_start && busy, 1);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrun_rst_busy",       busy,       0);
    chk("midrun_rst_resp_valid", resp_valid, 0);
    bad = 1'b0;
    for (int c = 0; c < 200; c++) begin
      step();
      @(negedge clk);
      if (resp_valid || busy) bad = 1'b1;
    end
    chk("midrun_rst_no_resp", bad, 0);
    rnd_valid = 1'b0; resp_ready = 1'b0;
    run_txn('{1, 0, 4, 2, 1'b0, 4}, rand256(), rand256());

    // Randomized traffic against a queue-based reference.
    do_reset();
    chk_reset_state();
    last_g = 1; inflight = 0; done_txn = 0; tokens = 0; acc = 2'b00;
    p[0] = '0; p[1] = '0; k[0] = '0; k[1] = '0;
    for (int cyc = 0; cyc < 30000 && done_txn < NRAND; cyc++) begin
      step();
      for (int r = 0; r < 2; r++) begin
        if (acc[r]) req_valid[r] = 1'b0;
        if (!req_valid[r] && ($urandom % 3 == 0)) begin
          p[r] = rand256();
          k[r] = rand256();
          req_pt[r*SW +: SW]  = p[r];
          req_key[r*SW +: SW] = k[r];
          req_valid[r] = 1'b1;
        end
      end
      rnd_valid  = ($urandom % 2) == 0;
      resp_ready = ($urandom % 3) != 0;
      @(negedge clk);
      acc = req_valid & req_ready;
      if (acc != 2'b00) begin
        if (req_valid == 2'b11) exp_g = 1 - last_g;
        else exp_g = req_valid[1] ? 1 : 0;
        chk("rand_grant", acc, (exp_g == 1) ? 2'b10 : 2'b01);
        chk("rand_accept_when_idle", inflight, 0);
        last_g   = exp_g;
        inflight = 1;
        tokens   = 0;
        lat      = ($urandom % 8 == 0) ? 0 : $urandom_range(1, 25);
        core_lat = lat;
        e.id  = exp_g[0];
        e.err = (lat == 0);
        e.ct  = e.err ? '0 : fake_aes(p[exp_g], k[exp_g]);
        q.push_back(e);
      end
      if (rnd_valid && rnd_ready) tokens++;
      if (resp_valid && resp_ready) begin
        if (q.size() == 0) begin
          chk("rand_unexpected_resp", 1, 0);
        end else begin
          e = q.pop_front();
          chk("rand_resp_id",  resp_id,  e.id);
          chk("rand_resp_err", resp_err, e.err);
          chk("rand_resp_ct",  resp_ct,  e.ct);
          chk("rand_tokens",   tokens,   1);
        end
        inflight = 0;
        done_txn++;
      end
    end
    chk("rand_txn_count", done_txn, NRAND);
    req_valid = 2'b00; rnd_valid = 1'b0; resp_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
